// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues word reads over a req/ack
// handshake, and buffers returned words with their PCs for the decode stage.
`timescale 1ns/1ps

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("ifu_fetch: DEPTH must be in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fpc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_pop;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];

    logic          pop;
    logic          ack;
    logic          push;
    logic          slot_free;
    logic          slot_after_push;
    logic [31:0]   fpc_inc;
    logic [31:0]   target;
    logic          unused_pc_bits;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inst_valid      = (count != '0);
        pop             = inst_valid && inst_ready;
        ack             = mem_ack && mem_req;
        push            = (state == BUSY) && mem_ack && !redirect_valid;
        count_pop       = count - CW'(pop);
        slot_free       = count_pop < DEPTH_C;
        slot_after_push = (count_pop + CW'(1)) < DEPTH_C;
        fpc_inc         = fpc + 32'd4;
        target          = {redirect_pc[31:2], 2'b00};
        unused_pc_bits  = ^redirect_pc[1:0];
        // Storage is not reset; outputs read as zero while empty.
        inst_pc         = inst_valid ? pc_mem[head]   : '0;
        inst_data       = inst_valid ? word_mem[head] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fpc;
            word_mem[tail] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fpc      <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            fpc   <= target;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            // A live request must still see its ack; its data is never kept.
            if (state != IDLE) begin
                if (ack) begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end else begin
                    state <= DROP;
                end
            end
        end else begin
            count <= count_pop + CW'(push);
            if (push) tail <= ptr_next(tail);
            if (pop)  head <= ptr_next(head);
            case (state)
                IDLE: begin
                    if (slot_free) begin
                        state    <= BUSY;
                        mem_req  <= 1'b1;
                        mem_addr <= fpc;
                    end
                end
                BUSY: begin
                    if (ack) begin
                        fpc <= fpc_inc;
                        if (slot_after_push) begin
                            mem_addr <= fpc_inc;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: reset trace table, directed corner sequences and a
// randomized run checked against a program-order stream model.
`timescale 1ns/1ps

module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready = 1'b1;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
        .inst_ready(inst_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stream model: the decode stage must see consecutive words from the last
    // redirect target, with at most DEPTH words fetched ahead of consumption.
    logic [31:0] exp_pc, exp_fetch, prev_addr, last_pc;
    int buffered, epoch, req_epoch, wcnt, lat, n_consumed, n_acks;
    bit prev_req, prev_ack, expect_issue, flush_chk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] data;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
        buffered = 0;
        epoch++;
        prev_req = 0;
        prev_ack = 0;
        expect_issue = 0;
        flush_chk = 0;
        wcnt = 0;
        n_acks = 0;
    endtask

    task automatic begin_cycle();
        bit new_req;
        @(negedge clk);
        if (!rst) begin
            check("inst_valid", 32'(inst_valid), 32'(buffered != 0));
            if (flush_chk) check("flush_valid", 32'(inst_valid), 32'd0);
            if (expect_issue) check("issue", 32'(mem_req), 32'd1);
            if (buffered == DEPTH) check("full_hold", 32'(mem_req), 32'd0);
            if (mem_req) check("addr_align", 32'(mem_addr[1:0]), 32'd0);
            if (mem_req && prev_req && !prev_ack) check("addr_stable", mem_addr, prev_addr);
            new_req = mem_req && (!prev_req || prev_ack);
            if (new_req) begin
                req_epoch = epoch;
                check("fetch_addr", mem_addr, exp_fetch);
            end
        end
        if (rst || !mem_req) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (wcnt >= lat - 1) begin
            mem_ack = 1'b1;
            wcnt = 0;
            n_acks++;
        end else begin
            mem_ack = 1'b0;
            wcnt++;
        end
        mem_rdata = mem_ack ? memf(mem_addr) : $urandom();
        redirect_valid = 1'b0;
    endtask

    task automatic end_cycle();
        bit pop;
        if (rst) begin
            reset_model();
        end else begin
            pop = inst_valid && inst_ready;
            expect_issue = !redirect_valid && !mem_req && (buffered - int'(pop) < DEPTH);
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                exp_fetch = exp_pc;
                buffered = 0;
                epoch++;
                flush_chk = 1;
            end else begin
                flush_chk = 0;
                if (pop) begin
                    check("inst_pc", inst_pc, exp_pc);
                    check("inst_data", inst_data, memf(exp_pc));
                    last_pc = inst_pc;
                    n_consumed++;
                    exp_pc += 32'd4;
                    buffered--;
                end
                if (mem_ack && mem_req && req_epoch == epoch) begin
                    exp_fetch += 32'd4;
                    buffered++;
                end
            end
            prev_req = mem_req;
            prev_ack = mem_ack && mem_req;
            prev_addr = mem_addr;
        end
        @(posedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic apply_reset();
        begin_cycle();
        rst = 1'b1;
        end_cycle();
        begin_cycle();
        rst = 1'b0;
        end_cycle();
    endtask

    task automatic wait_consume(input string name, input logic [31:0] exp);
        int c0;
        bit ok;
        c0 = n_consumed;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            begin_cycle();
            end_cycle();
            if (n_consumed != c0) begin
                ok = 1;
                break;
            end
        end
        check({name, "_seen"}, 32'(ok), 32'd1);
        if (ok) check(name, last_pc, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        epoch = 0;
        n_consumed = 0;
        last_pc = '0;
        req_epoch = 0;
        reset_model();
        lat = 1;

        // Zero-wait memory, decode always ready: exact trace from reset.
        tbl[0] = '{1'b0, 32'h0000_3000, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b1, 32'h0000_3004, 1'b1, 32'h0000_3000, memf(32'h0000_3000)};
        tbl[3] = '{1'b1, 32'h0000_3008, 1'b1, 32'h0000_3004, memf(32'h0000_3004)};
        tbl[4] = '{1'b1, 32'h0000_300C, 1'b1, 32'h0000_3008, memf(32'h0000_3008)};
        tbl[5] = '{1'b1, 32'h0000_3010, 1'b1, 32'h0000_300C, memf(32'h0000_300C)};
        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            begin_cycle();
            check($sformatf("tbl%0d_req", i), 32'(mem_req), 32'(tbl[i].req));
            check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
            if (tbl[i].valid || i == 0) begin
                check($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
                check($sformatf("tbl%0d_data", i), inst_data, tbl[i].data);
            end
            if (i == 0) rst = 1'b0;
            end_cycle();
        end
        run(20);

        // Three-cycle memory latency: one instruction every three cycles.
        lat = 3;
        apply_reset();
        begin
            int c0;
            c0 = n_consumed;
            run(30);
            check("lat3_count", 32'(n_consumed - c0), 32'd9);
        end

        // Decode stalled: buffer fills to DEPTH, then issue resumes after a pop.
        lat = 1;
        inst_ready = 1'b0;
        apply_reset();
        run(10);
        begin_cycle();
        check("stall_acks", 32'(n_acks), 32'd2);
        check("stall_req", 32'(mem_req), 32'd0);
        check("stall_head", inst_pc, 32'h0000_3000);
        inst_ready = 1'b1;
        end_cycle();
        begin_cycle();
        check("resume_req", 32'(mem_req), 32'd1);
        check("resume_addr", mem_addr, 32'h0000_3008);
        end_cycle();
        run(10);

        // Redirect while the fetch of 0x3008 is in flight.
        lat = 3;
        apply_reset();
        found = 0;
        for (int i = 0; i < 60; i++) begin
            begin_cycle();
            if (mem_req && mem_addr == 32'h0000_3008 && !mem_ack) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h0000_3043;
                found = 1;
            end
            end_cycle();
            if (found) break;
        end
        check("redir_found", 32'(found), 32'd1);
        begin_cycle();
        check("redir_flush", 32'(inst_valid), 32'd0);
        check("redir_drop_req", 32'(mem_req), 32'd1);
        check("redir_drop_addr", mem_addr, 32'h0000_3008);
        end_cycle();
        wait_consume("redir_first_pc", 32'h0000_3040);

        // Redirect coincident with an ack and a pop.
        lat = 1;
        apply_reset();
        run(4);
        begin_cycle();
        check("coinc_setup", 32'(inst_valid && mem_ack), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_5000;
        end_cycle();
        begin_cycle();
        check("coinc_flush", 32'(inst_valid), 32'd0);
        check("coinc_req", 32'(mem_req), 32'd0);
        end_cycle();
        begin_cycle();
        check("coinc_req_target", 32'(mem_req), 32'd1);
        check("coinc_addr_target", mem_addr, 32'h0000_5000);
        end_cycle();
        run(6);

        // Redirect to the top of the address space wraps to zero.
        begin_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        end_cycle();
        wait_consume("wrap_pc0", 32'hFFFF_FFFC);
        wait_consume("wrap_pc1", 32'h0000_0000);

        // Asynchronous reset in the middle of a busy request.
        lat = 3;
        inst_ready = 1'b0;
        apply_reset();
        run(4);
        begin_cycle();
        check("rst_pre_req", 32'(mem_req), 32'd1);
        check("rst_pre_valid", 32'(inst_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_addr", mem_addr, RESET_PC);
        end_cycle();
        begin_cycle();
        rst = 1'b0;
        inst_ready = 1'b1;
        end_cycle();
        wait_consume("rst_refetch", 32'h0000_3000);

        // Randomized latency, decode back-pressure and redirects.
        lat = 2;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            begin_cycle();
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom();
            end
            end_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
